// File: rtl/lcd_pkg.sv
// lcd_pkg -- shared definitions for the HD44780 write sequencer.
//   * lcd_state_e : sequencer states
//   * bit positions of the LSU LCD register word and of the status word
//   * power-up init command list (used only when LCD_INIT_EN is defined)
//   * cyc_m1()      : cycle count -> timer load value (0 treated as 1)
//   * is_long_cmd() : clear/home commands that need the long execution wait
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      EN_HI,
      HOLD,
      EXEC,
      PWRUP
   } lcd_state_e;

   // LCD register word fields
   localparam int unsigned ON_BIT   = 31;
   localparam int unsigned CLR_BIT  = 11;
   localparam int unsigned REQ_BIT  = 10;
   localparam int unsigned RS_BIT   = 9;
   localparam int unsigned DATA_MSB = 7;
   localparam int unsigned DATA_LSB = 0;

   // status word bits
   localparam int unsigned BUSY_BIT = 0;
   localparam int unsigned PEND_BIT = 1;
   localparam int unsigned OVR_BIT  = 2;

   // init sequence: function set, display on, clear, entry mode (entry 0 first)
   localparam int unsigned INIT_LEN = 4;
   localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {8'h06, 8'h01, 8'h0C, 8'h38};

   function automatic logic [31:0] cyc_m1(input int unsigned n);
      return (n == 0) ? 32'd0 : 32'(n - 1);
   endfunction

   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data inside {8'h01, 8'h02, 8'h03});
   endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// lcd_ctrl_if -- LSU-side bus of the LCD sequencer.
//   lcd_word : LCD register word written by software (LSU -> sequencer)
//   status   : busy / pending / overrun status word (sequencer -> LSU)
// master = LSU side, slave = sequencer side.
interface lcd_ctrl_if;
   logic [31:0] lcd_word;
   logic [31:0] status;

   modport master (output lcd_word, input status);
   modport slave  (input lcd_word, output status);
endinterface

// File: rtl/lcd_ctrl_timer.sv
// lcd_timer -- loadable down-counter used for every timed sequencer phase.
//   clk_i, rst_ni : clock, asynchronous active-low reset (loads RST_VAL)
//   load_i, val_i : load val_i (N-1 for an N-cycle phase)
//   done_o        : counter has reached zero
module lcd_timer #(
   parameter int unsigned     CNT_W   = 20,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] val_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= RST_VAL;
      end else if (load_i) begin
         cnt <= val_i;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign done_o = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl -- HD44780 write sequencer driven by the LSU LCD register word.
// A toggle of word bit 10 requests one write of {RS=bit 9, DATA=bits 7:0};
// the block produces the setup / EN pulse / hold waveform and then waits out
// the LCD execution time. One extra request can be queued while busy; a
// further one is dropped and flagged as overrun until bit 11 clears it.
// Optional build macro: LCD_INIT_EN adds a power-up wait plus the
// 38/0C/01/06 init sequence after reset.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : lcd_ctrl_if.slave (lcd_word in, status out:
//                   [0] busy, [1] pending valid, [2] overrun)
//   lcd_data_o    : LCD data bus
//   lcd_rs_o      : register select
//   lcd_rw_o      : read/write, tied to 0 (write only)
//   lcd_en_o      : enable strobe
//   lcd_on_o      : power/backlight, word bit 31 delayed one cycle
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP     = 2,
   parameter int unsigned T_EN_HI     = 12,
   parameter int unsigned T_HOLD      = 2,
   parameter int unsigned T_EXEC      = 2000,
   parameter int unsigned T_EXEC_LONG = 82000,
   parameter int unsigned T_PWRUP     = 750000,
   parameter int unsigned CNT_W       = 20
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   lcd_ctrl_if.slave  bus,
   output logic [7:0] lcd_data_o,
   output logic       lcd_rs_o,
   output logic       lcd_rw_o,
   output logic       lcd_en_o,
   output logic       lcd_on_o
);

   localparam logic [CNT_W-1:0] M1_SETUP     = CNT_W'(cyc_m1(T_SETUP));
   localparam logic [CNT_W-1:0] M1_EN_HI     = CNT_W'(cyc_m1(T_EN_HI));
   localparam logic [CNT_W-1:0] M1_HOLD      = CNT_W'(cyc_m1(T_HOLD));
   localparam logic [CNT_W-1:0] M1_EXEC      = CNT_W'(cyc_m1(T_EXEC));
   localparam logic [CNT_W-1:0] M1_EXEC_LONG = CNT_W'(cyc_m1(T_EXEC_LONG));

   lcd_state_e       state;
   logic [31:0]      word;
   logic             prev_tog, req, req_rs, clr;
   logic [7:0]       req_data;
   logic             pend_v, pend_rs, ovr;
   logic [7:0]       pend_data;
   logic             tmr_load, tmr_done;
   logic [CNT_W-1:0] tmr_val;
   logic             in_idle, exec_end, init_more, init_step;
   logic             serve_pend, start_req, enter_setup;
   logic             nxt_rs;
   logic [7:0]       nxt_data, init_data;
   logic             unused_word;

   assign word     = bus.lcd_word;
   assign req      = word[REQ_BIT] ^ prev_tog;
   assign req_rs   = word[RS_BIT];
   assign req_data = word[DATA_MSB:DATA_LSB];
   assign clr      = word[CLR_BIT];
   assign unused_word = ^{word[30:12], word[8]};

`ifdef LCD_INIT_EN
   localparam lcd_state_e       RST_STATE = PWRUP;
   localparam logic [CNT_W-1:0] TMR_RST   = CNT_W'(cyc_m1(T_PWRUP));
   logic [2:0] init_idx;   // number of init commands already issued
   assign init_more = (32'(init_idx) < INIT_LEN);
   assign init_data = INIT_CMDS[init_idx[1:0]];
`else
   localparam lcd_state_e       RST_STATE = IDLE;
   localparam logic [CNT_W-1:0] TMR_RST   = '0;
   logic unused_cfg;
   assign unused_cfg = (T_PWRUP == 0);
   assign init_more  = 1'b0;
   assign init_data  = '0;
`endif

   lcd_timer #(
      .CNT_W  (CNT_W),
      .RST_VAL(TMR_RST)
   ) u_timer (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .load_i(tmr_load),
      .val_i (tmr_val),
      .done_o(tmr_done)
   );

   // Decisions for this cycle. The timer is reloaded on the same edge the
   // state changes, so each phase lasts exactly N cycles.
   always_comb begin
      in_idle     = (state == IDLE);
      exec_end    = (state == EXEC) && tmr_done;
      init_step   = init_more && (exec_end || ((state == PWRUP) && tmr_done));
      serve_pend  = pend_v && !init_step && (in_idle || exec_end);
      start_req   = in_idle && req && !pend_v;
      enter_setup = init_step || serve_pend || start_req;

      if (init_step) begin
         nxt_rs   = 1'b0;
         nxt_data = init_data;
      end else if (serve_pend) begin
         nxt_rs   = pend_rs;
         nxt_data = pend_data;
      end else begin
         nxt_rs   = req_rs;
         nxt_data = req_data;
      end

      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         IDLE, EXEC, PWRUP: begin
            tmr_load = enter_setup;
            tmr_val  = M1_SETUP;
         end
         SETUP: begin
            tmr_load = tmr_done;
            tmr_val  = M1_EN_HI;
         end
         EN_HI: begin
            tmr_load = tmr_done;
            tmr_val  = M1_HOLD;
         end
         HOLD: begin
            tmr_load = tmr_done;
            tmr_val  = is_long_cmd(lcd_rs_o, lcd_data_o) ? M1_EXEC_LONG : M1_EXEC;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= RST_STATE;
         lcd_en_o   <= 1'b0;
         lcd_rs_o   <= 1'b0;
         lcd_data_o <= '0;
`ifdef LCD_INIT_EN
         init_idx   <= '0;
`endif
      end else begin
         // RS/DATA only change when a write enters SETUP
         if (enter_setup) begin
            lcd_rs_o   <= nxt_rs;
            lcd_data_o <= nxt_data;
         end
`ifdef LCD_INIT_EN
         if (init_step) init_idx <= init_idx + 3'd1;
`endif
         case (state)
            IDLE, EXEC, PWRUP: begin
               if (enter_setup)   state <= SETUP;
               else if (exec_end) state <= IDLE;
            end
            SETUP: if (tmr_done) begin
               state    <= EN_HI;
               lcd_en_o <= 1'b1;
            end
            EN_HI: if (tmr_done) begin
               state    <= HOLD;
               lcd_en_o <= 1'b0;
            end
            HOLD: if (tmr_done) state <= EXEC;
            default: state <= IDLE;
         endcase
      end
   end

   // Pending slot and overrun. In IDLE a queued write is served first and a
   // simultaneous new request takes its place in the slot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_v    <= 1'b0;
         pend_rs   <= 1'b0;
         pend_data <= '0;
         ovr       <= 1'b0;
      end else begin
         if (serve_pend) pend_v <= 1'b0;
         if (req && (in_idle ? pend_v : !pend_v)) begin
            pend_v    <= 1'b1;
            pend_rs   <= req_rs;
            pend_data <= req_data;
         end
         if (req && !in_idle && pend_v) ovr <= 1'b1;
         else if (clr)                  ovr <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_tog <= 1'b0;
         lcd_on_o <= 1'b0;
      end else begin
         prev_tog <= word[REQ_BIT];
         lcd_on_o <= word[ON_BIT];
      end
   end

   assign lcd_rw_o = 1'b0;

   always_comb begin
      bus.status           = '0;
      bus.status[BUSY_BIT] = !in_idle;
      bus.status[PEND_BIT] = pend_v;
      bus.status[OVR_BIT]  = ovr;
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl -- self-checking bench for lcd_ctrl with shortened timing.
// The reference model tracks each LCD write as a start edge plus its
// duration and derives EN / busy / RS / DATA from that timeline.
module tb_lcd_ctrl;

   localparam int TS = 2, TE = 3, TH = 2, TX = 5, TXL = 20, TP = 10;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b1;
   logic [7:0] lcd_data;
   logic       lcd_rs, lcd_rw, lcd_en, lcd_on;

   lcd_ctrl_if bus();

   lcd_ctrl #(
      .T_SETUP    (TS),
      .T_EN_HI    (TE),
      .T_HOLD     (TH),
      .T_EXEC     (TX),
      .T_EXEC_LONG(TXL),
      .T_PWRUP    (TP),
      .CNT_W      (20)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .bus       (bus),
      .lcd_data_o(lcd_data),
      .lcd_rs_o  (lcd_rs),
      .lcd_rw_o  (lcd_rw),
      .lcd_en_o  (lcd_en),
      .lcd_on_o  (lcd_on)
   );

   always #5 clk = ~clk;

   int total = 0, passed = 0;
   int k = 0;                // index of the last clock edge
   int bcnt = 0, ecnt = 0;   // busy / EN cycles seen since last cleared

   // reference model state
   int         m_start, m_end;        // start edge of current write, edge it leaves EXEC
   logic       m_rs, m_prs, m_pv, m_ovr, m_tog, m_on;
   logic [7:0] m_data, m_pdata;
   logic       cur_tog = 1'b0, cur_on = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, k);
   endtask

   function automatic int exec_len(input logic rs, input logic [7:0] d);
      return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? TXL : TX;
   endfunction

   task automatic model_reset();
      m_start = -1000; m_end = -1000;
      m_rs = 1'b0; m_data = 8'h00;
      m_pv = 1'b0; m_prs = 1'b0; m_pdata = 8'h00;
      m_ovr = 1'b0; m_tog = 1'b0; m_on = 1'b0;
   endtask

   task automatic model_start(input logic rs, input logic [7:0] d);
      m_start = k;
      m_rs    = rs;
      m_data  = d;
      m_end   = k + TS + TE + TH + exec_len(rs, d);
   endtask

   task automatic model_edge(input logic req, input logic rs, input logic [7:0] d, input logic clr);
      logic pv, busy_before, set_ovr;
      pv = m_pv;
      busy_before = (k > m_start) && (k <= m_end);
      set_ovr = 1'b0;
      if (!busy_before) begin
         if (pv) begin
            model_start(m_prs, m_pdata);
            m_pv = 1'b0;
            if (req) begin m_prs = rs; m_pdata = d; m_pv = 1'b1; end
         end else if (req) begin
            model_start(rs, d);
         end
      end else begin
         if (k == m_end && pv) begin
            model_start(m_prs, m_pdata);
            m_pv = 1'b0;
         end
         if (req) begin
            if (!pv) begin m_prs = rs; m_pdata = d; m_pv = 1'b1; end
            else set_ovr = 1'b1;
         end
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
   endtask

   task automatic check_all();
      logic en_exp, busy_exp;
      en_exp   = (k >= m_start + TS) && (k < m_start + TS + TE);
      busy_exp = (k < m_end);
      check("en", 32'(lcd_en), 32'(en_exp));
      check("status", bus.status, {29'b0, m_ovr, m_pv, busy_exp});
      check("data", 32'(lcd_data), 32'(m_data));
      check("rs", 32'(lcd_rs), 32'(m_rs));
      check("on", 32'(lcd_on), 32'(m_on));
      check("rw", 32'(lcd_rw), 32'd0);
   endtask

   task automatic step(input logic tog, input logic rs, input logic [7:0] d,
                       input logic clr, input logic on, input logic [18:0] junk);
      bus.lcd_word = {on, junk, clr, tog, rs, junk[0], d};
      @(posedge clk);
      k++;
      model_edge(tog ^ m_tog, rs, d, clr);
      m_tog = tog;
      m_on  = on;
      #1;
      bcnt += int'(bus.status[0]);
      ecnt += int'(lcd_en);
      check_all();
   endtask

   task automatic idle(input int n);
      repeat (n) step(cur_tog, 1'b0, 8'h00, 1'b0, cur_on, 19'd0);
   endtask

   task automatic req(input logic rs, input logic [7:0] d);
      cur_tog = ~cur_tog;
      step(cur_tog, rs, d, 1'b0, cur_on, 19'd0);
   endtask

   task automatic wait_init();
`ifdef LCD_INIT_EN
      logic [7:0] init_exp [4];
      logic [7:0] got [4];
      int seen, n;
      logic pen;
      init_exp = '{8'h38, 8'h0C, 8'h01, 8'h06};
      got = '{8'h00, 8'h00, 8'h00, 8'h00};
      seen = 0; n = 0; pen = 1'b0;
      bus.lcd_word = '0;
      check("init_busy", 32'(bus.status[0]), 32'd1);
      while (n < 2000 && !(seen == 4 && bus.status[0] == 1'b0)) begin
         @(posedge clk);
         k++; n++;
         #1;
         if (lcd_en && !pen) begin
            if (seen < 4) got[seen] = lcd_data;
            check("init_rs", 32'(lcd_rs), 32'd0);
            seen++;
         end
         pen = lcd_en;
      end
      check("init_pulses", 32'(seen), 32'd4);
      for (int i = 0; i < 4; i++) check("init_cmd", 32'(got[i]), 32'(init_exp[i]));
      check("init_done", 32'(bus.status[0]), 32'd0);
      m_rs = 1'b0;
      m_data = 8'h06;
`else
      check("post_reset_idle", 32'(bus.status[0]), 32'd0);
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      int k0, k42;
      logic       r_rs, r_clr;
      logic [7:0] r_d;

      // reset state
      bus.lcd_word = '0;
      model_reset();
      #1 rst_ni = 1'b0;
      #2;
      check("rst_en", 32'(lcd_en), 32'd0);
      check("rst_status", bus.status, 32'd0);
      check("rst_data", {23'd0, lcd_rs, lcd_data}, 32'd0);
      check("rst_on", 32'(lcd_on), 32'd0);
      @(posedge clk); @(posedge clk);
      #3 rst_ni = 1'b1;
      k = 0;
      wait_init();

      // single data write
      bcnt = 0; ecnt = 0;
      req(1'b1, 8'h41);
      check("busy_next", 32'(bus.status[0]), 32'd1);
      idle(19);
      check("t1_busy_len", 32'(bcnt), 32'd12);
      check("t1_en_len", 32'(ecnt), 32'd3);

      // clear uses the long wait, other commands do not
      bcnt = 0; req(1'b0, 8'h01); idle(34);
      check("clear_busy_len", 32'(bcnt), 32'd27);
      bcnt = 0; req(1'b0, 8'h80); idle(19);
      check("cmd80_busy_len", 32'(bcnt), 32'd12);
      bcnt = 0; req(1'b1, 8'h02); idle(19);
      check("rs1_02_busy_len", 32'(bcnt), 32'd12);

      // pending then overrun, then clear
      req(1'b1, 8'h41);
      k0 = k;
      idle(2);
      req(1'b1, 8'h42);
      check("pend_status", bus.status, 32'h3);
      req(1'b1, 8'h43);
      check("ovr_status", bus.status, 32'h7);
      k42 = -1;
      for (int i = 0; i < 30; i++) begin
         idle(1);
         if (k42 < 0 && lcd_data == 8'h42) k42 = k;
      end
      check("pend_start", 32'(k42), 32'(k0 + 12));
      check("ovr_sticky", bus.status, 32'h4);
      step(cur_tog, 1'b0, 8'h00, 1'b1, cur_on, 19'd0);
      check("ovr_clr", bus.status, 32'h0);
      idle(2);

      // reset during EN high
      req(1'b1, 8'h55);
      idle(2);
      check("en_before_rst", 32'(lcd_en), 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      check("rst_async_en", 32'(lcd_en), 32'd0);
      check("rst_async_status", bus.status, 32'd0);
      bus.lcd_word = '0;
      cur_tog = 1'b0;
      @(posedge clk);
      k++;
      #2 rst_ni = 1'b1;
      model_reset();
      wait_init();
      ecnt = 0;
      idle(20);
      check("no_pulse_after_rst", 32'(ecnt), 32'd0);

      // backlight bit
      bcnt = 0;
      cur_on = 1'b1;
      idle(1);
      check("on_follow", 32'(lcd_on), 32'd1);
      idle(3);
      cur_on = 1'b0;
      idle(1);
      check("on_off", 32'(lcd_on), 32'd0);
      check("on_no_cycle", 32'(bcnt), 32'd0);

      // random traffic against the model
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(5) == 0) cur_tog = ~cur_tog;
         r_rs = 1'($urandom);
         case ($urandom_range(3))
            0:       r_d = 8'h01;
            1:       r_d = 8'($urandom_range(3));
            default: r_d = 8'($urandom);
         endcase
         r_clr  = ($urandom_range(19) == 0);
         cur_on = 1'($urandom);
         step(cur_tog, r_rs, r_d, r_clr, cur_on, 19'($urandom));
      end
      idle(40);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
